// File: rtl/imem_loader.sv
// Byte-stream loader that writes a framed program image into instruction memory and holds the core
// in reset until the image is complete. Optional trailing XOR checksum: define IMEM_LOADER_CSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

`ifdef IMEM_LOADER_CSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;
    localparam state_t LAST_ST = CSUM;
`else
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;
    localparam state_t LAST_ST = DONE;
`endif

    localparam int unsigned CAPACITY = 2 ** ADDR_W;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [1:0]          lane_q, lane_d;
    logic [23:0]         asm_q, asm_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [15:0]         words_q, words_d;
    logic                handshake;
    logic [31:0]         len_full;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    // Status outputs are pure decodes of the registered state.
`ifdef IMEM_LOADER_CSUM_EN
    assign s_ready = (state_q inside {LEN_LO, LEN_HI, DATA, CSUM});
`else
    assign s_ready = (state_q inside {LEN_LO, LEN_HI, DATA});
`endif
    assign busy         = s_ready;
    assign core_rst     = (state_q != DONE);
    assign done         = (state_q == DONE);
    assign err          = (state_q == ERR);
    assign imem_we      = we_q;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;

    assign handshake = s_valid && s_ready;
    assign len_full  = {16'd0, s_data, len_q[7:0]};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        words_d = words_q;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d  = handshake ? (csum_q ^ s_data) : csum_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN_LO;
                    lane_d  = 2'd0;
                    asm_d   = 24'd0;
                    words_d = 16'd0;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d  = 8'd0;
`endif
                end
            end
            LEN_LO: begin
                if (handshake) begin
                    len_d[7:0] = s_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (handshake) begin
                    len_d[15:8] = s_data;
                    if (len_full > CAPACITY)
                        state_d = ERR;
                    else if (len_full == 32'd0)
                        state_d = LAST_ST;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                // The write and the word count both land one cycle after the fourth byte.
                if (handshake) begin
                    if (lane_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = words_q[ADDR_W-1:0];
                        wdata_d = {s_data, asm_q};
                        words_d = words_q + 16'd1;
                        lane_d  = 2'd0;
                        if (words_q + 16'd1 == len_q)
                            state_d = LAST_ST;
                    end else begin
                        case (lane_q)
                            2'd0:    asm_d[7:0]   = s_data;
                            2'd1:    asm_d[15:8]  = s_data;
                            default: asm_d[23:16] = s_data;
                        endcase
                        lane_d = lane_q + 2'd1;
                    end
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: begin
                if (handshake)
                    state_d = ((csum_q ^ s_data) == 8'd0) ? DONE : ERR;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= 16'd0;
            lane_q  <= 2'd0;
            asm_q   <= 24'd0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'd0;
            words_q <= 16'd0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            words_q <= words_d;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are checked against a reference parser of the frame
// format (word N = bytes 2+4N..5+4N little-endian, written one cycle after its last byte).
module tb_imem_loader;
    localparam int ADDR_W   = 8;
    localparam int CAPACITY = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       words_loaded;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int                hs_cyc[$];
    logic [7:0]        hs_byte[$];
    int                wr_cyc[$];
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    logic [7:0]        tx_q[$];
    int                hs_base;
    int                wr_base;

    typedef struct {
        int len;
        int min_gap;
        int max_gap;
        bit exp_err;
    } vec_t;

    // Byte transfers are observed at the edge where they happen; writes between edges.
    always @(posedge clk) begin
        if (s_valid && s_ready) begin
            hs_cyc.push_back(cyc);
            hs_byte.push_back(s_data);
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (imem_we) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(imem_waddr);
            wr_data.push_back(imem_wdata);
        end
    end

    initial begin
        #(2_000_000);
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " s_ready"},      32'(s_ready),      32'd0);
        checkOutput({tag, " imem_we"},      32'(imem_we),      32'd0);
        checkOutput({tag, " imem_waddr"},   32'(imem_waddr),   32'd0);
        checkOutput({tag, " imem_wdata"},   imem_wdata,        32'd0);
        checkOutput({tag, " core_rst"},     32'(core_rst),     32'd1);
        checkOutput({tag, " busy"},         32'(busy),         32'd0);
        checkOutput({tag, " done"},         32'(done),         32'd0);
        checkOutput({tag, " err"},          32'(err),          32'd0);
        checkOutput({tag, " words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic addChecksum();
`ifdef IMEM_LOADER_CSUM_EN
        logic [7:0] x;
        int n;
        x = 8'd0;
        n = int'({tx_q[1], tx_q[0]});
        if (n <= CAPACITY) begin
            foreach (tx_q[i]) x = x ^ tx_q[i];
            tx_q.push_back(x);
        end
`endif
    endtask

    task automatic buildFrame(input int len);
        logic [15:0] l16;
        l16 = len[15:0];
        tx_q = {};
        tx_q.push_back(l16[7:0]);
        tx_q.push_back(l16[15:8]);
        if (len <= CAPACITY)
            for (int i = 0; i < 4 * len; i++) tx_q.push_back(8'($urandom));
        addChecksum();
    endtask

    // A byte is presented alongside start; it must not be consumed because s_ready is low.
    task automatic doStart();
        @(negedge clk);
        hs_base = hs_cyc.size();
        wr_base = wr_cyc.size();
        start   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b0;
        checkOutput("no byte taken with start", 32'(hs_cyc.size() - hs_base), 32'd0);
    endtask

    task automatic applyStimulus(input int min_gap, input int max_gap);
        int gap;
        int waited;
        for (int i = 0; i < tx_q.size(); i++) begin
            gap = int'($urandom_range(max_gap, min_gap));
            s_valid = 1'b0;
            repeat (gap) @(negedge clk);
            s_valid = 1'b1;
            s_data  = tx_q[i];
            waited  = 0;
            while (!s_ready && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (!s_ready) begin
                checkOutput("s_ready timeout", 32'(s_ready), 32'd1);
                break;
            end
            if (i == 0) checkOutput("core_rst while loading", 32'(core_rst), 32'd1);
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    // Reference parser: every frame byte is consumed, word i is bytes 2+4i..5+4i, written at
    // address i exactly one cycle after its last byte.
    task automatic checkWrites();
        int n;
        int nexp;
        int got;
        int hsn;
        int last;
        logic [31:0] w;
        n    = int'({tx_q[1], tx_q[0]});
        nexp = (n > CAPACITY) ? 0 : n;
        got  = wr_cyc.size() - wr_base;
        hsn  = hs_cyc.size() - hs_base;
        checkOutput("bytes consumed", 32'(hsn), 32'(tx_q.size()));
        for (int i = 0; i < tx_q.size() && i < hsn; i++)
            if (hs_byte[hs_base + i] !== tx_q[i])
                checkOutput($sformatf("byte[%0d]", i), 32'(hs_byte[hs_base + i]), 32'(tx_q[i]));
        checkOutput("write count", 32'(got), 32'(nexp));
        for (int i = 0; i < nexp && i < got; i++) begin
            w    = {tx_q[2 + 4*i + 3], tx_q[2 + 4*i + 2], tx_q[2 + 4*i + 1], tx_q[2 + 4*i]};
            last = 2 + 4*i + 3;
            checkOutput($sformatf("waddr[%0d]", i), 32'(wr_addr[wr_base + i]), 32'(i % CAPACITY));
            checkOutput($sformatf("wdata[%0d]", i), wr_data[wr_base + i], w);
            if (last < hsn)
                checkOutput($sformatf("latency[%0d]", i),
                            32'(wr_cyc[wr_base + i] - hs_cyc[hs_base + last]), 32'd1);
        end
    endtask

    task automatic finishFrame(input bit exp_err, input int exp_wl);
        repeat (2) @(negedge clk);
        checkWrites();
        checkOutput("done",         32'(done),         32'(!exp_err));
        checkOutput("err",          32'(err),          32'(exp_err));
        checkOutput("core_rst",     32'(core_rst),     32'(exp_err));
        checkOutput("words_loaded", 32'(words_loaded), 32'(exp_wl));
        checkOutput("s_ready idle", 32'(s_ready),      32'd0);
        checkOutput("busy idle",    32'(busy),         32'd0);
    endtask

    task automatic frameOne();
        tx_q = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    endtask

    initial begin
        vec_t vecs[7];
        int   len;

        vecs[0] = '{len: 1,     min_gap: 0, max_gap: 0, exp_err: 1'b0};
        vecs[1] = '{len: 3,     min_gap: 0, max_gap: 2, exp_err: 1'b0};
        vecs[2] = '{len: 5,     min_gap: 1, max_gap: 3, exp_err: 1'b0};
        vecs[3] = '{len: 256,   min_gap: 0, max_gap: 0, exp_err: 1'b0};
        vecs[4] = '{len: 257,   min_gap: 0, max_gap: 1, exp_err: 1'b1};
        vecs[5] = '{len: 65535, min_gap: 0, max_gap: 0, exp_err: 1'b1};
        vecs[6] = '{len: 0,     min_gap: 0, max_gap: 2, exp_err: 1'b0};

        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) @(negedge clk);
        checkReset("reset");
        rst = 1'b0;
        @(negedge clk);
        checkReset("idle");

        $display("[TB] two-word frame, back-to-back");
        frameOne(); addChecksum();
        doStart(); applyStimulus(0, 0); finishFrame(1'b0, 2);

        $display("[TB] empty frame");
        tx_q = {8'h00, 8'h00}; addChecksum();
        doStart(); applyStimulus(0, 0);
`ifndef IMEM_LOADER_CSUM_EN
        checkOutput("done right after LEN_HI", 32'(done), 32'd1);
        checkOutput("core_rst released", 32'(core_rst), 32'd0);
`endif
        finishFrame(1'b0, 0);

        $display("[TB] length overflow N=257");
        tx_q = {8'h01, 8'h01};
        doStart(); applyStimulus(0, 0); finishFrame(1'b1, 0);

        $display("[TB] two-word frame with idle gaps");
        frameOne(); addChecksum();
        doStart(); applyStimulus(1, 3); finishFrame(1'b0, 2);

        $display("[TB] reset mid-load");
        tx_q = {8'h02, 8'h00, 8'h13, 8'h00};
        doStart(); applyStimulus(0, 0);
        rst = 1'b1;
        @(negedge clk);
        checkReset("mid-load reset");
        rst = 1'b0;
        frameOne(); addChecksum();
        doStart(); applyStimulus(0, 0); finishFrame(1'b0, 2);

`ifdef IMEM_LOADER_CSUM_EN
        $display("[TB] checksum good and bad");
        frameOne(); tx_q.push_back(8'hD2);
        doStart(); applyStimulus(0, 0); finishFrame(1'b0, 2);
        frameOne(); tx_q.push_back(8'hD3);
        doStart(); applyStimulus(0, 0); finishFrame(1'b1, 2);
`endif

        $display("[TB] vector table");
        for (int v = 0; v < 7; v++) begin
            buildFrame(vecs[v].len);
            doStart();
            applyStimulus(vecs[v].min_gap, vecs[v].max_gap);
            finishFrame(vecs[v].exp_err, vecs[v].exp_err ? 0 : vecs[v].len);
        end

        $display("[TB] random frames");
        for (int r = 0; r < 6; r++) begin
            len = (r == 5) ? int'($urandom_range(400, 257)) : int'($urandom_range(40, 1));
            buildFrame(len);
            doStart();
            applyStimulus(0, int'($urandom_range(2, 0)));
            finishFrame(len > CAPACITY, (len > CAPACITY) ? 0 : len);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
